bpf_forwarder: RTL and testbench
================================

Name: bpf_forwarder

Overview:
- Sits directly downstream of the BPF CPU core.
- Consumes the one-cycle accept/reject verdict pulses for the packet buffer the CPU has just filtered.
- On accept, reads the packet out of the forwarder port of packet memory as 64-bit words and streams it on an AXI-Stream-style master.
- On accept or reject, returns the buffer to packet memory with a done pulse, and keeps saturating accept/reject statistics.

Parameters:
- SNOOP_FWD_ADDR_WIDTH, 9, word address width of the forwarder port of packet memory; one word is 64 bits.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_acc  in  1  one-cycle accept pulse from the CPU core.
- cpu_rej  in  1  one-cycle reject pulse from the CPU core.
- packet_len  in  SNOOP_FWD_ADDR_WIDTH  number of valid 64-bit words in the buffer; sampled only in the verdict cycle.
- fwd_rd_en  out  1  packet memory read enable.
- fwd_addr  out  SNOOP_FWD_ADDR_WIDTH  packet memory word address.
- fwd_rd_data  in  64  read data; valid exactly 1 cycle after fwd_rd_en.
- m_tdata  out  64  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  marks the final beat.
- fwd_done  out  1  one-cycle pulse that releases the buffer to packet memory.
- busy  out  1  high while a verdict is being processed.
- acc_cnt  out  CNT_WIDTH  number of accepted packets.
- rej_cnt  out  CNT_WIDTH  number of rejected packets.

Behaviour:
- Reset: while rst is 0, all outputs are 0, the FSM is in IDLE, the output buffer is empty and in-flight reads are discarded. This takes effect asynchronously, including mid-packet.
  - A packet interrupted by reset is not completed and gets no fwd_done.
  - Release is synchronous to clk.
- FSM states: IDLE, STREAM, DONE.
- IDLE, on cpu_rej=1 (including cpu_rej and cpu_acc both 1; reject wins): rej_cnt+1, go to DONE.
- IDLE, on cpu_acc=1 alone: acc_cnt+1, latch len=packet_len, clear issue/beat counters.
  - len=0: go to DONE; no beats are sent.
  - Otherwise: go to STREAM.
- IDLE, no pulse: stay in IDLE.
- Verdict pulses outside IDLE are ignored and not counted.
- STREAM, read issue:
  - Addresses 0..len-1, ascending, each issued once.
  - Issue rule: a read is issued in a cycle iff issued<len and (occ + inflight - pop) < 2.
    - occ = entries in the 2-entry output FIFO.
    - inflight = read issued in the previous cycle.
    - pop = m_tvalid & m_tready.
  - fwd_addr holds its last value when fwd_rd_en is 0.
- STREAM, data return: returned data is pushed into the FIFO in the cycle it is valid. m_tvalid=1 from the cycle after the push while occ>0.
- STREAM, stream output:
  - m_tdata is the FIFO head; it must not change while m_tvalid=1 and m_tready=0.
  - m_tlast=1 only on beat len-1.
  - Go to DONE in the cycle after the tlast handshake.
- DONE: fwd_done=1 for exactly one cycle, then go to IDLE. A new verdict is accepted in the cycle after DONE.
- busy = (state != IDLE).
- Latency with m_tready held at 1:
  - Accept at cycle 0: first read at cycle 1, first m_tvalid at cycle 3.
  - Then 1 beat per cycle with no bubbles.
  - For len=N, last beat at cycle N+2, fwd_done at cycle N+3.
- Latency for reject or len=0: verdict at cycle 0, fwd_done at cycle 1, busy high only in cycle 1.
- Backpressure: no data loss or duplication for any m_tready pattern, because the FIFO never overflows under the issue rule.
- Counters: wrap is forbidden; at 2^CNT_WIDTH-1 they hold.
- Boundary: packet_len = 2^SNOOP_FWD_ADDR_WIDTH-1 (511) streams 511 beats; the address never wraps.

Test Plan:
- Reset, then cpu_acc with packet_len=4, words 0xA0..0xA3, m_tready=1 → fwd_rd_en at cycles 1-4 with addr 0-3; beats A0..A3 at cycles 3-6, tlast at cycle 6; fwd_done at cycle 7; acc_cnt=1.
- cpu_rej, then cpu_acc+cpu_rej in the same cycle → no m_tvalid; two fwd_done pulses, each 1 cycle after its verdict; rej_cnt=2, acc_cnt=0.
- Accept with len=8 and m_tready random at 30% → exactly 8 beats in order, data stable while stalled, tlast only on beat 8, no read re-issued.
- Accept with len=0 → fwd_done at cycle 1, no reads, no beats, acc_cnt+1.
- Assert rst low mid-stream at beat 3 of 10 → m_tvalid, busy and fwd_rd_en drop immediately, no fwd_done; after release, a new accept with len=2 streams correctly.
- Force acc_cnt to 0xFFFFFFFF, then accept → acc_cnt stays 0xFFFFFFFF; cpu_acc asserted while busy is ignored.

Source files
------------

// File: rtl/bpf_forwarder.sv
// Post-filter forwarder: on an accept verdict streams the packet buffer out of
// packet memory as 64-bit beats, then releases the buffer and updates statistics.
module bpf_forwarder #(
    parameter int SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_acc,
    input  logic                            cpu_rej,
    input  logic [SNOOP_FWD_ADDR_WIDTH-1:0] packet_len,
    output logic                            fwd_rd_en,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0] fwd_addr,
    input  logic [63:0]                     fwd_rd_data,
    output logic [63:0]                     m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            fwd_done,
    output logic                            busy,
    output logic [CNT_WIDTH-1:0]            acc_cnt,
    output logic [CNT_WIDTH-1:0]            rej_cnt
);

    // state  | meaning
    // IDLE   | waiting for a verdict pulse
    // STREAM | issuing reads and draining the output FIFO
    // DONE   | one-cycle buffer release
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int AW = SNOOP_FWD_ADDR_WIDTH;
    localparam logic [AW-1:0]        ADDR_ONE = AW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [1:0]           state_q, state_d;
    logic [AW-1:0]        len_q, len_d;
    logic [AW-1:0]        issued_q, issued_d;
    logic [AW-1:0]        beats_q, beats_d;
    logic [AW-1:0]        last_addr_q, last_addr_d;
    logic                 inflight_q;
    logic [1:0]           occ_q, occ_d;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [63:0]          fifo_q [2];
    logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_WIDTH-1:0] rej_cnt_q, rej_cnt_d;

    logic       issue;
    logic       push;
    logic       pop;
    logic       room;
    logic [2:0] fill_lvl;
    logic [2:0] fill_lim;

    assign push     = inflight_q;
    assign m_tvalid = (occ_q != 2'd0);
    assign m_tdata  = fifo_q[rd_ptr_q];
    assign m_tlast  = m_tvalid && (beats_q == (len_q - ADDR_ONE));
    assign pop      = m_tvalid && m_tready;

    // A new read may be issued only if the FIFO still has room once every
    // outstanding read has landed, counting the slot freed by this cycle's pop.
    assign fill_lvl = {1'b0, occ_q} + {2'b00, inflight_q};
    assign fill_lim = 3'd2 + {2'b00, pop};
    assign room     = (fill_lvl < fill_lim);
    assign issue    = (state_q == ST_STREAM) && (issued_q < len_q) && room;

    assign fwd_rd_en   = issue;
    assign fwd_addr    = issue ? issued_q : last_addr_q;
    assign last_addr_d = fwd_addr;

    assign fwd_done = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);
    assign acc_cnt  = acc_cnt_q;
    assign rej_cnt  = rej_cnt_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        issued_d  = issued_q;
        beats_d   = beats_q;
        acc_cnt_d = acc_cnt_q;
        rej_cnt_d = rej_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_rej) begin
                    if (rej_cnt_q != CNT_MAX) rej_cnt_d = rej_cnt_q + CNT_ONE;
                    state_d = ST_DONE;
                end else if (cpu_acc) begin
                    if (acc_cnt_q != CNT_MAX) acc_cnt_d = acc_cnt_q + CNT_ONE;
                    len_d    = packet_len;
                    issued_d = '0;
                    beats_d  = '0;
                    state_d  = (packet_len == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (issue) issued_d = issued_q + ADDR_ONE;
                if (pop) begin
                    beats_d = beats_q + ADDR_ONE;
                    if (m_tlast) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)      occ_d = occ_q + 2'd1;
        else if (pop && !push) occ_d = occ_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            beats_q     <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            acc_cnt_q   <= '0;
            rej_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            beats_q     <= beats_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= issue;
            acc_cnt_q   <= acc_cnt_d;
            rej_cnt_q   <= rej_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            occ_q <= occ_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= fwd_rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

endmodule

// File: tb/tb_bpf_forwarder.sv
// Directed bench for bpf_forwarder: packet-memory model, event logs sampled on
// the falling edge, and hand-derived cycle expectations relative to the verdict.
`timescale 1ns/1ps
module tb_bpf_forwarder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_acc = 1'b0, cpu_rej = 1'b0;
    logic [8:0]  packet_len = '0;
    logic        fwd_rd_en;
    logic [8:0]  fwd_addr;
    logic [63:0] fwd_rd_data;
    logic [63:0] m_tdata;
    logic        m_tvalid, m_tlast, fwd_done, busy;
    logic        m_tready = 1'b1;
    logic [31:0] acc_cnt, rej_cnt;

    // narrow-counter instance for saturation
    logic        s_acc = 1'b0, s_rej = 1'b0;
    logic [8:0]  s_len = '0;
    logic        s_rd_en, s_tvalid, s_tlast, s_done, s_busy;
    logic [8:0]  s_addr;
    logic [63:0] s_tdata;
    logic [1:0]  s_acc_cnt, s_rej_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rnd_ready = 1'b0;

    logic [63:0] pmem [512];
    logic [63:0] rd_data_q = '0;

    int          rd_cyc[$];
    int          rd_addr[$];
    int          bt_cyc[$];
    logic [63:0] bt_data[$];
    bit          bt_last[$];
    int          dn_cyc[$];
    int          busy_cyc[$];

    bit          prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    bpf_forwarder #(.SNOOP_FWD_ADDR_WIDTH(9), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .cpu_acc(cpu_acc), .cpu_rej(cpu_rej),
        .packet_len(packet_len), .fwd_rd_en(fwd_rd_en), .fwd_addr(fwd_addr),
        .fwd_rd_data(fwd_rd_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .fwd_done(fwd_done),
        .busy(busy), .acc_cnt(acc_cnt), .rej_cnt(rej_cnt)
    );

    bpf_forwarder #(.SNOOP_FWD_ADDR_WIDTH(9), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .cpu_acc(s_acc), .cpu_rej(s_rej),
        .packet_len(s_len), .fwd_rd_en(s_rd_en), .fwd_addr(s_addr),
        .fwd_rd_data(64'd0), .m_tdata(s_tdata), .m_tvalid(s_tvalid),
        .m_tready(1'b1), .m_tlast(s_tlast), .fwd_done(s_done),
        .busy(s_busy), .acc_cnt(s_acc_cnt), .rej_cnt(s_rej_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (fwd_rd_en) rd_data_q <= pmem[fwd_addr];
    assign fwd_rd_data = rd_data_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (fwd_rd_en) begin
                rd_cyc.push_back(cyc);
                rd_addr.push_back(int'(fwd_addr));
            end
            if (m_tvalid && m_tready) begin
                bt_cyc.push_back(cyc);
                bt_data.push_back(m_tdata);
                bt_last.push_back(m_tlast);
            end
            if (fwd_done) dn_cyc.push_back(cyc);
            if (busy) busy_cyc.push_back(cyc);
            if (prev_stall) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", m_tdata, prev_data);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        rd_cyc.delete(); rd_addr.delete(); bt_cyc.delete(); bt_data.delete();
        bt_last.delete(); dn_cyc.delete(); busy_cyc.delete();
    endtask

    task automatic fill(input logic [63:0] base);
        for (int i = 0; i < 512; i++) pmem[i] = base + 64'(i);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {fwd_rd_en, m_tvalid, m_tlast, fwd_done, busy}, 0);
        check("rst_addr", fwd_addr, 0);
        check("rst_data", m_tdata, 0);
        check("rst_cnt", {acc_cnt, rej_cnt}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit acc, input bit rej, input int len, output int t0);
        @(posedge clk);
        #1;
        cpu_acc = acc; cpu_rej = rej; packet_len = 9'(len);
        t0 = cyc;
        @(posedge clk);
        #1;
        cpu_acc = 1'b0; cpu_rej = 1'b0; packet_len = '0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (dn_cyc.size() == 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_seen", dn_cyc.size() > 0, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input int t0, input int n, input bit timed);
        int bad;
        check("rd_count", rd_addr.size(), n);
        bad = 0;
        foreach (rd_addr[i]) begin
            if (rd_addr[i] != i) bad++;
            if (timed && rd_cyc[i] != t0 + 1 + i) bad++;
        end
        check("rd_order", bad, 0);
        check("beat_count", bt_data.size(), n);
        bad = 0;
        foreach (bt_data[i]) begin
            if (bt_data[i] !== pmem[i]) bad++;
            if (bt_last[i] != (i == n - 1)) bad++;
            if (timed && bt_cyc[i] != t0 + 3 + i) bad++;
        end
        check("beat_content", bad, 0);
        check("done_count", dn_cyc.size(), 1);
        if (dn_cyc.size() > 0 && bt_cyc.size() > 0)
            check("done_after_last", dn_cyc[0], bt_cyc[bt_cyc.size() - 1] + 1);
        if (timed && dn_cyc.size() > 0)
            check("done_latency", dn_cyc[0], t0 + n + 3);
    endtask

    task automatic check_short(input int t0);
        check("short_done_count", dn_cyc.size(), 1);
        if (dn_cyc.size() > 0) check("short_done_cyc", dn_cyc[0], t0 + 1);
        check("short_busy_len", busy_cyc.size(), 1);
        if (busy_cyc.size() > 0) check("short_busy_cyc", busy_cyc[0], t0 + 1);
        check("short_no_reads", rd_addr.size(), 0);
        check("short_no_beats", bt_data.size(), 0);
    endtask

    task automatic sat_pulse(input bit acc, input bit rej);
        @(posedge clk);
        #1;
        s_acc = acc; s_rej = rej;
        @(posedge clk);
        #1;
        s_acc = 1'b0; s_rej = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int waited;
        logic [31:0] acc_before, rej_before;

        // accept, len 4, ready always high
        do_reset();
        for (int i = 0; i < 512; i++) pmem[i] = 64'hA0 + 64'(i);
        clear_logs();
        pulse(1, 0, 4, t0);
        wait_done(50);
        check_stream(t0, 4, 1);
        check("t1_busy_cycles", busy_cyc.size(), 7);
        check("t1_acc", acc_cnt, 1);
        check("t1_rej", rej_cnt, 0);

        // reject, then accept+reject together
        do_reset();
        clear_logs();
        pulse(0, 1, 5, t0);
        wait_done(20);
        check_short(t0);
        clear_logs();
        pulse(1, 1, 4, t0);
        wait_done(20);
        check_short(t0);
        check("t2_rej", rej_cnt, 2);
        check("t2_acc", acc_cnt, 0);

        // len 8 under random backpressure
        fill(64'hC0DE_0000_0000_1000);
        clear_logs();
        rnd_ready = 1'b1;
        pulse(1, 0, 8, t0);
        wait_done(600);
        rnd_ready = 1'b0;
        check_stream(t0, 8, 0);
        check("t3_acc", acc_cnt, 1);

        // zero-length accept
        acc_before = acc_cnt;
        clear_logs();
        pulse(1, 0, 0, t0);
        wait_done(20);
        check_short(t0);
        check("t4_acc_inc", acc_cnt, acc_before + 32'd1);

        // reset mid-stream at beat 3 of 10
        fill(64'h5500_0000_0000_0000);
        clear_logs();
        pulse(1, 0, 10, t0);
        waited = 0;
        while (bt_data.size() < 3 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("t5_reached_beat3", bt_data.size(), 3);
        check("t5_pre_rst_valid", m_tvalid, 1);
        rst = 1'b0;
        #1;
        check("t5_rst_ctrl", {m_tvalid, busy, fwd_rd_en, fwd_done, m_tlast}, 0);
        check("t5_rst_data", m_tdata, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t5_no_done", dn_cyc.size(), 0);
        check("t5_acc_cleared", acc_cnt, 0);
        fill(64'h7700_0000_0000_0020);
        clear_logs();
        pulse(1, 0, 2, t0);
        wait_done(30);
        check_stream(t0, 2, 1);
        check("t5_acc", acc_cnt, 1);

        // verdicts while busy are ignored
        fill(64'h9900_0000_0000_0040);
        acc_before = acc_cnt;
        rej_before = rej_cnt;
        clear_logs();
        pulse(1, 0, 4, t0);
        cpu_acc = 1'b1; packet_len = 9'd9;
        @(posedge clk);
        #1;
        cpu_acc = 1'b0; cpu_rej = 1'b1;
        @(posedge clk);
        #1;
        cpu_rej = 1'b0; packet_len = '0;
        wait_done(50);
        check_stream(t0, 4, 1);
        check("t6_acc_once", acc_cnt, acc_before + 32'd1);
        check("t6_rej_same", rej_cnt, rej_before);
        check("t6_idle_after", busy, 0);

        // maximum length: 511 beats, address never wraps
        fill(64'hDA7A_0000_0000_0000);
        clear_logs();
        pulse(1, 0, 511, t0);
        wait_done(700);
        check_stream(t0, 511, 1);
        if (rd_addr.size() > 0) check("t7_last_addr", rd_addr[rd_addr.size() - 1], 510);

        // counter saturation on a 2-bit-counter instance
        do_reset();
        sat_pulse(1, 0); check("sat_acc1", s_acc_cnt, 1);
        sat_pulse(1, 0); check("sat_acc2", s_acc_cnt, 2);
        sat_pulse(1, 0); check("sat_acc3", s_acc_cnt, 3);
        sat_pulse(1, 0); check("sat_acc_hold", s_acc_cnt, 3);
        sat_pulse(0, 1); sat_pulse(0, 1); sat_pulse(0, 1);
        check("sat_rej3", s_rej_cnt, 3);
        sat_pulse(0, 1); check("sat_rej_hold", s_rej_cnt, 3);
        check("sat_quiet", {s_rd_en, s_tvalid, s_tlast, s_done, s_busy}, 0);
        check("sat_outs", {s_addr, s_tdata[54:0]}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
